// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter, 16x oversampled, 11-bit frame with even parity
module uart_tx (
  input  logic       clk16x,
  input  logic       clrn,
  input  logic       wrn,
  input  logic [7:0] d_in,
  output logic       txd,
  output logic       t_empty,
  output logic       t_busy,
  output logic       overrun,
  output logic [3:0] cnt16x,
  output logic [3:0] no_bits_sent,
  output logic [7:0] t_buffer
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state;
  logic        wrn_d;
  logic [10:0] shreg;
  logic        write_ev;
  logic [10:0] frame;

  // One event per low pulse: only the falling edge of wrn counts.
  assign write_ev = ~wrn & wrn_d;
  assign frame    = {1'b1, ^t_buffer, t_buffer, 1'b0};

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      state        <= IDLE;
      wrn_d        <= 1'b1;
      shreg        <= '1;
      txd          <= 1'b1;
      t_empty      <= 1'b1;
      t_busy       <= 1'b0;
      overrun      <= 1'b0;
      cnt16x       <= 4'd0;
      no_bits_sent <= 4'd0;
      t_buffer     <= 8'd0;
    end else begin
      wrn_d <= wrn;

      // A write needs t_empty=1 and a load needs t_empty=0, so they never collide.
      if (write_ev) begin
        if (t_empty) begin
          t_buffer <= d_in;
          t_empty  <= 1'b0;
        end else begin
          overrun  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!t_empty) begin
            shreg        <= frame;
            txd          <= 1'b0;
            t_empty      <= 1'b1;
            cnt16x       <= 4'd0;
            no_bits_sent <= 4'd0;
            t_busy       <= 1'b1;
            state        <= SHIFT;
          end else begin
            txd <= 1'b1;
          end
        end
        default: begin
          cnt16x <= cnt16x + 4'd1;
          txd    <= shreg[0];
          if (cnt16x == 4'd15) begin
            if (no_bits_sent != 4'd10) begin
              shreg        <= {1'b1, shreg[10:1]};
              txd          <= shreg[1];
              no_bits_sent <= no_bits_sent + 4'd1;
            end else if (!t_empty) begin
              // Back-to-back: next start bit follows the stop bit with no gap.
              shreg        <= frame;
              txd          <= 1'b0;
              t_empty      <= 1'b1;
              no_bits_sent <= 4'd0;
            end else begin
              state  <= IDLE;
              t_busy <= 1'b0;
              txd    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-timing model
module tb_uart_tx;

  logic       clk16x = 1'b0;
  logic       clrn   = 1'b0;
  logic       wrn    = 1'b1;
  logic [7:0] d_in   = 8'd0;
  logic       txd, t_empty, t_busy, overrun;
  logic [3:0] cnt16x, no_bits_sent;
  logic [7:0] t_buffer;

  uart_tx dut (
    .clk16x(clk16x), .clrn(clrn), .wrn(wrn), .d_in(d_in),
    .txd(txd), .t_empty(t_empty), .t_busy(t_busy), .overrun(overrun),
    .cnt16x(cnt16x), .no_bits_sent(no_bits_sent), .t_buffer(t_buffer)
  );

  always #5 clk16x = ~clk16x;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  // Model: a holding slot plus the current frame and its age in clk16x cycles.
  logic       m_prev_wrn = 1'b1, m_full = 1'b0, m_active = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_hold = 8'd0, m_byte = 8'd0;
  int         m_age = 0;

  always @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      m_prev_wrn = 1'b1; m_full = 1'b0; m_active = 1'b0; m_ovr = 1'b0;
      m_hold = 8'd0; m_byte = 8'd0; m_age = 0;
    end else begin : model_step
      logic ev, was_full;
      ev         = !wrn && m_prev_wrn;
      m_prev_wrn = wrn;
      was_full   = m_full;
      if (m_active) begin
        m_age++;
        if (m_age == 176) begin
          if (was_full) begin m_byte = m_hold; m_full = 1'b0; m_age = 0; end
          else m_active = 1'b0;
        end
      end else if (was_full) begin
        m_active = 1'b1; m_byte = m_hold; m_full = 1'b0; m_age = 0;
      end
      if (ev) begin
        if (was_full) m_ovr = 1'b1;
        else begin m_hold = d_in; m_full = 1'b1; end
      end
    end
  end

  logic cmp_on = 1'b0;
  int   busy_rises = 0;
  logic prev_busy = 1'b0;

  always begin : compare
    logic [10:0] fr;
    logic        exp_txd;
    @(posedge clk16x);
    #1;
    if (cmp_on) begin
      fr      = frame_of(m_byte);
      exp_txd = m_active ? fr[m_age / 16] : 1'b1;
      chk("txd", txd, exp_txd);
      chk("t_empty", t_empty, !m_full);
      chk("t_busy", t_busy, m_active);
      chk("overrun", overrun, m_ovr);
      chk("t_buffer", t_buffer, m_hold);
      if (m_active) begin
        chk("cnt16x", cnt16x, m_age % 16);
        chk("no_bits_sent", no_bits_sent, m_age / 16);
      end
    end
    if (t_busy && !prev_busy) busy_rises++;
    prev_busy = t_busy;
  end

  // Receiver: samples txd mid-bit after each falling start edge.
  logic [10:0] frames[$];
  initial begin : collector
    logic [10:0] fr;
    forever begin
      @(posedge clk16x);
      #1;
      if (clrn === 1'b1 && txd === 1'b0) begin
        for (int k = 0; k < 11; k++) begin
          repeat ((k == 0) ? 8 : 16) @(posedge clk16x);
          #1;
          fr[k] = txd;
        end
        frames.push_back(fr);
      end
    end
  end

  task automatic wr(input logic [7:0] b, input int len);
    @(negedge clk16x);
    d_in = b;
    wrn  = 1'b0;
    repeat (len) @(negedge clk16x);
    wrn  = 1'b1;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 2000 && frames.size() < n; i++) @(posedge clk16x);
    #2;
    chk("frames_seen", frames.size(), n);
  endtask

  task automatic expect_frame(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = (frames.size() > 0) ? frames.pop_front() : 11'h000;
    chk(name, got, exp);
  endtask

  initial begin : main
    logic [10:0] fr;
    logic [7:0]  lb[3];
    int          b0;
    logic        hit;

    repeat (3) @(posedge clk16x);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_t_empty", t_empty, 1);
    chk("rst_t_busy", t_busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cnt16x", cnt16x, 0);
    chk("rst_no_bits", no_bits_sent, 0);
    chk("rst_t_buffer", t_buffer, 0);
    @(negedge clk16x);
    clrn   = 1'b1;
    cmp_on = 1'b1;
    repeat (4) @(negedge clk16x);

    // 0x55: t_empty 1->0->1 over two edges, start bit right after load.
    d_in = 8'h55;
    wrn  = 1'b0;
    @(posedge clk16x); #1;
    chk("lat_t_empty_e0", t_empty, 0);
    @(negedge clk16x);
    wrn = 1'b1;
    @(posedge clk16x); #1;
    chk("lat_t_empty_e1", t_empty, 1);
    chk("lat_txd_e1", txd, 0);
    chk("lat_busy_e1", t_busy, 1);
    wait_frames(1);
    expect_frame("frame_55", 11'h4AA);
    repeat (20) @(posedge clk16x);
    #1;
    chk("idle_busy_55", t_busy, 0);
    chk("idle_txd_55", txd, 1);

    wr(8'hA7, 1);
    wait_frames(1);
    expect_frame("frame_a7", 11'h74E);
    repeat (20) @(posedge clk16x);
    wr(8'h00, 1);
    wait_frames(1);
    expect_frame("frame_00", 11'h400);
    repeat (20) @(posedge clk16x);

    // Back-to-back: second byte written during the first frame.
    b0 = busy_rises;
    wr(8'h01, 1);
    repeat (30) @(negedge clk16x);
    wr(8'h80, 1);
    wait_frames(2);
    expect_frame("b2b_first", 11'h602);
    expect_frame("b2b_second", 11'h700);
    repeat (30) @(posedge clk16x);
    #1;
    chk("b2b_one_busy_span", busy_rises - b0, 1);
    chk("b2b_overrun", overrun, 0);

    // Three quick writes: the third is an overrun.
    wr(8'h12, 1);
    repeat (5) @(negedge clk16x);
    wr(8'h34, 1);
    repeat (5) @(negedge clk16x);
    wr(8'h56, 1);
    @(posedge clk16x); #1;
    chk("ovr_set", overrun, 1);
    wait_frames(2);
    expect_frame("ovr_first", frame_of(8'h12));
    expect_frame("ovr_second", frame_of(8'h34));
    repeat (300) @(posedge clk16x);
    #1;
    chk("ovr_only_two", frames.size(), 0);
    chk("ovr_sticky", overrun, 1);

    wr(8'h9A, 100);
    wait_frames(1);
    expect_frame("long_pulse", frame_of(8'h9A));
    repeat (300) @(posedge clk16x);
    #1;
    chk("long_pulse_one", frames.size(), 0);

    // Asynchronous reset in the middle of bit 4.
    wr(8'hC3, 1);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(posedge clk16x); #1;
      if (no_bits_sent == 4'd4) hit = 1'b1;
    end
    chk("bit4_reached", hit, 1);
    #2;
    clrn = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1);
    chk("mid_rst_busy", t_busy, 0);
    chk("mid_rst_t_empty", t_empty, 1);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_cnt16x", cnt16x, 0);
    chk("mid_rst_no_bits", no_bits_sent, 0);
    chk("mid_rst_t_buffer", t_buffer, 0);
    @(negedge clk16x);
    clrn = 1'b1;
    repeat (200) @(posedge clk16x);
    frames.delete();
    wr(8'h5A, 1);
    wait_frames(1);
    expect_frame("post_rst_frame", frame_of(8'h5A));
    repeat (20) @(posedge clk16x);

    // Receiver-side decode of three back-to-back bytes.
    lb[0] = 8'h3C; lb[1] = 8'hFF; lb[2] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 400 && t_empty !== 1'b1; j++) @(negedge clk16x);
      wr(lb[i], 1);
    end
    wait_frames(3);
    for (int i = 0; i < 3; i++) begin
      fr = (frames.size() > 0) ? frames.pop_front() : 11'h000;
      chk("rx_byte", fr[8:1], lb[i]);
      chk("rx_parity_ok", ^fr[9:1], 0);
      chk("rx_start_ok", fr[0], 0);
      chk("rx_stop_ok", fr[10], 1);
    end

    // Random writes at random gaps and pulse widths; the compare process checks every cycle.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk16x);
      wr(8'($urandom), int'($urandom_range(1, 4)));
    end
    repeat (400) @(posedge clk16x);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter. It is the transmit-side companion of the UART receiver in the IO_Peripherals UART block.
- The CPU writes a byte through an active-low write strobe into a one-byte holding buffer.
- The block serialises each byte as an 11-bit frame: start(0), d[0]..d[7] LSB first, even parity, stop(1). Each bit lasts 16 clk16x cycles.
- Fully synchronous to clk16x. No derived clocks.

Parameters:
- none. Frame format and 16x oversampling are fixed to match the receiver.

Ports:
- clk16x  in  1  16x baud clock.
- clrn  in  1  Reset: asynchronous, active-low. The block is clocked by clk16x.
- wrn  in  1  Active-low write strobe, synchronous to clk16x.
- d_in  in  8  Byte to transmit, sampled with the accepted write.
- txd  out  1  Serial output; idles high.
- t_empty  out  1  Holding buffer empty; a write is accepted only while high.
- t_busy  out  1  Frame shifting in progress.
- overrun  out  1  Sticky flag: a write arrived while t_empty=0.
- cnt16x  out  4  Intra-bit counter (debug).
- no_bits_sent  out  4  Bit index 0..10 of the current frame (debug).
- t_buffer  out  8  Holding register contents (debug).

Behaviour:
- Reset values (async, clrn=0): txd=1, t_empty=1, t_busy=0, overrun=0, cnt16x=0, no_bits_sent=0, t_buffer=0, shift register=all ones, FSM=IDLE. A reset mid-frame forces txd high immediately and abandons the frame.
- Write detection: wrn is registered into wrn_d (reset value 1). A write event occurs on the edge where wrn=0 and wrn_d=1. This gives exactly one event per low pulse, regardless of pulse length.
- Write event with t_empty=1: t_buffer<=d_in, t_empty<=0.
- Write event with t_empty=0: the write is ignored and overrun<=1. overrun clears only on clrn.
- Parity: p = ^t_buffer (even). For every frame the XOR of d[7:0] and p equals 0.
- Shift register: 11 bits, loaded as {1, p, t_buffer, 0}. txd is driven from shreg[0] through a register.
- FSM IDLE:
  - t_empty=1: stay in IDLE, txd=1.
  - t_empty=0: load shreg, set t_empty<=1, cnt16x<=0, no_bits_sent<=0, t_busy<=1, go to SHIFT.
- FSM SHIFT: cnt16x increments every cycle and wraps 15->0.
  - At cnt16x=15 with no_bits_sent<10: shift right (fill with 1) and increment no_bits_sent.
  - At cnt16x=15 with no_bits_sent=10 (stop bit complete) and t_empty=0: reload from t_buffer immediately, with no idle gap. t_empty<=1, no_bits_sent<=0, remain in SHIFT.
  - At cnt16x=15 with no_bits_sent=10 and t_empty=1: go to IDLE, t_busy<=0, txd stays 1.
- Latency:
  - Write accepted at edge E0: t_empty=0 after E0.
  - Load at E1: txd=0 and t_empty=1 after E1.
  - Each bit is held exactly 16 cycles; a frame lasts 176 cycles.
- Concurrency: a write and a load never coincide, because a load requires t_empty=0 and a write requires t_empty=1. A write arriving on the same edge as the reload, while t_empty is still 0, counts as an overrun.
- Writing during SHIFT while t_empty=1 is legal. The byte is held and sent back-to-back after the current stop bit.

Test Plan:
- Reset, then a write pulse of 0x55 -> t_empty 1->0->1 over 2 edges. txd sequence per 16-cycle bit: 0,1,0,1,0,1,0,1,0,0(parity),1(stop). t_busy=0 and txd=1 after 176 cycles.
- Write 0xA7 (5 ones) -> parity bit=1. Write 0x00 -> parity bit=0 and the frame is 0 for 10 bits, then stop=1.
- Write 0x01, then 0x80 during the first frame -> two contiguous frames, 352 cycles with t_busy continuously 1. Second start bit begins the cycle after the first stop bit ends. overrun=0.
- Three writes within 20 cycles -> first byte shifting, second held, third ignored. overrun=1 and stays set until clrn. Only two frames are emitted.
- Hold wrn low for 100 cycles -> exactly one byte is transmitted.
- Assert clrn mid-frame (bit 4) -> txd=1 asynchronously and all outputs at reset values. A following write transmits a clean frame.
- Loopback txd->uart_rx.rxd with a shared clk16x, sending 0x3C, 0xFF, 0x81 -> receiver frame matches each byte, parity_error=0, frame_error=0.
